// File: rtl/vm_pkg.sv
// Shared coin codes, coin-to-value decoding and default prices for the
// two-product vending controller.
package vm_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_5    = 3'b001;
    localparam logic [2:0] COIN_10   = 3'b010;
    localparam logic [2:0] COIN_20   = 3'b100;

    // Prices are expressed in 5-unit multiples.
    localparam int DEFAULT_PRICE0   = 3;
    localparam int DEFAULT_PRICE1   = 4;
    localparam int DEFAULT_CREDIT_W = 4;

    // Non one-hot codes carry no value.
    function automatic logic [2:0] coin_value(input logic [2:0] code);
        logic [2:0] val;
        case (code)
            COIN_5:  val = 3'd1;
            COIN_10: val = 3'd2;
            COIN_20: val = 3'd4;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_coin_detect.sv
// Edge detector on the coin code: a valid code counts once on the cycle it
// first differs from the previously sampled code.
module vm_coin_detect
    import vm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i,
    output logic [2:0] coin_val
);

    logic [2:0] i_prev_reg;

    // Tracks every code, invalid ones included, so a held coin never repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_prev_reg <= COIN_NONE;
        end else begin
            i_prev_reg <= i;
        end
    end

    assign coin_val = (i != i_prev_reg) ? coin_value(i) : 3'd0;

endmodule

// File: rtl/vending_machine.sv
// Coin-accumulating controller: adds detected coins to a running credit and
// issues a one-cycle dispense pulse with change once the selected price is met.
module vending_machine
    import vm_pkg::*;
#(
    parameter int PRICE0   = DEFAULT_PRICE0,
    parameter int PRICE1   = DEFAULT_PRICE1,
    parameter int CREDIT_W = DEFAULT_CREDIT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i,
    input  logic       choice,
    output logic       out,
    output logic [2:0] ret
);

    // One spare bit so credit plus the largest coin never wraps in the compare.
    localparam int EW = CREDIT_W + 1;

    logic [2:0]          coin_val;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                out_reg, out_next;
    logic [2:0]          ret_reg, ret_next;
    logic [EW-1:0]       eff;
    logic [EW-1:0]       price;

    vm_coin_detect u_coin_detect (
        .clk      (clk),
        .rst      (rst),
        .i        (i),
        .coin_val (coin_val)
    );

    always_comb begin
        eff         = EW'(credit_reg) + EW'(coin_val);
        price       = choice ? EW'(PRICE1) : EW'(PRICE0);
        credit_next = CREDIT_W'(eff);
        out_next    = 1'b0;
        ret_next    = 3'd0;
        if (eff >= price) begin
            out_next    = 1'b1;
            ret_next    = 3'(eff - price);
            credit_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_reg <= '0;
            out_reg    <= 1'b0;
            ret_reg    <= 3'd0;
        end else begin
            credit_reg <= credit_next;
            out_reg    <= out_next;
            ret_reg    <= ret_next;
        end
    end

    assign out = out_reg;
    assign ret = ret_reg;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: a credit-level reference model checked
// every cycle, plus literal per-step expectations.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] i = 3'b000;
    logic       choice = 1'b0;
    logic       out;
    logic [2:0] ret;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model state
    int   m_credit = 0;
    logic [2:0] m_prev = 3'b000;
    logic exp_out = 1'b0;
    logic [2:0] exp_ret = 3'd0;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .i      (i),
        .choice (choice),
        .out    (out),
        .ret    (ret)
    );

    always #5 clk = ~clk;

    function automatic int worth(input logic [2:0] code);
        case (code)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credit = 0;
            m_prev   = 3'b000;
            exp_out  = 1'b0;
            exp_ret  = 3'd0;
        end else begin
            int total;
            int price;
            total = m_credit + ((i != m_prev) ? worth(i) : 0);
            price = choice ? 4 : 3;
            if (total >= price) begin
                exp_out  = 1'b1;
                exp_ret  = 3'(total - price);
                m_credit = 0;
            end else begin
                exp_out  = 1'b0;
                exp_ret  = 3'd0;
                m_credit = total;
            end
            m_prev = i;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (out !== exp_out || ret !== exp_ret) begin
                errors++;
                $display("FAIL model t=%0t out=%0b ret=%0d required out=%0b ret=%0d",
                         $time, out, ret, exp_out, exp_ret);
            end
        end
    end

    task automatic lit(input string name, input logic eo, input logic [2:0] er);
        checks++;
        if (out !== eo || ret !== er) begin
            errors++;
            $display("FAIL %s out=%0b ret=%0d required out=%0b ret=%0d", name, out, ret, eo, er);
        end
    endtask

    // Apply inputs away from the edge, then check the registered result.
    task automatic step(input string name, input logic [2:0] code, input logic ch,
                        input logic eo, input logic [2:0] er);
        @(negedge clk);
        i = code;
        choice = ch;
        @(posedge clk);
        #1;
        $display("step %-12s i=%b choice=%0b -> out=%0b ret=%0d", name, code, ch, out, ret);
        lit(name, eo, er);
    endtask

    initial begin
        // Reset held with a 20 coin present
        i = 3'b100;
        choice = 1'b1;
        #1 rst = 1'b0;
        #1 lit("rst_async", 1'b0, 3'd0);
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 lit("rst_held", 1'b0, 3'd0);

        // Release with coin still present: counts once
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 lit("rel_vend", 1'b1, 3'd0);
        step("rel_hold", 3'b100, 1'b1, 1'b0, 3'd0);
        step("rel_idle", 3'b000, 1'b1, 1'b0, 3'd0);

        // Exact pay, product 0
        step("ex_10a", 3'b010, 1'b0, 1'b0, 3'd0);
        step("ex_10b", 3'b010, 1'b0, 1'b0, 3'd0);
        step("ex_gap", 3'b000, 1'b0, 1'b0, 3'd0);
        step("ex_5a", 3'b001, 1'b0, 1'b1, 3'd0);
        step("ex_5b", 3'b001, 1'b0, 1'b0, 3'd0);
        step("ex_idle", 3'b000, 1'b0, 1'b0, 3'd0);

        // Change
        step("ch_10", 3'b010, 1'b0, 1'b0, 3'd0);
        step("ch_gap", 3'b000, 1'b0, 1'b0, 3'd0);
        step("ch_20", 3'b100, 1'b0, 1'b1, 3'd3);
        step("ch_idle", 3'b000, 1'b0, 1'b0, 3'd0);

        // Adjacent distinct coins
        step("adj_5", 3'b001, 1'b1, 1'b0, 3'd0);
        step("adj_10", 3'b010, 1'b1, 1'b0, 3'd0);
        step("adj_5v", 3'b001, 1'b1, 1'b1, 3'd0);
        step("adj_idle", 3'b000, 1'b1, 1'b0, 3'd0);

        // Invalid codes add nothing; then a choice switch alone vends
        step("inv_011", 3'b011, 1'b1, 1'b0, 3'd0);
        step("inv_111", 3'b111, 1'b1, 1'b0, 3'd0);
        step("inv_110", 3'b110, 1'b1, 1'b0, 3'd0);
        step("inv_101", 3'b101, 1'b1, 1'b0, 3'd0);
        step("inv_000", 3'b000, 1'b1, 1'b0, 3'd0);
        step("sw_10", 3'b010, 1'b1, 1'b0, 3'd0);
        step("sw_5", 3'b001, 1'b1, 1'b0, 3'd0);
        step("sw_hold", 3'b000, 1'b1, 1'b0, 3'd0);
        step("sw_choice", 3'b000, 1'b0, 1'b1, 3'd0);
        step("sw_after", 3'b000, 1'b0, 1'b0, 3'd0);

        // Back-to-back vends
        step("bb_20", 3'b100, 1'b0, 1'b1, 3'd1);
        step("bb_10", 3'b010, 1'b0, 1'b0, 3'd0);
        step("bb_5", 3'b001, 1'b0, 1'b1, 3'd0);
        step("bb_idle", 3'b000, 1'b0, 1'b0, 3'd0);

        // Asynchronous clear while out is high
        step("ar_10", 3'b010, 1'b1, 1'b0, 3'd0);
        step("ar_20", 3'b100, 1'b1, 1'b1, 3'd2);
        i = 3'b000;
        #2 rst = 1'b0;
        #1 lit("ar_clear", 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        step("ar_idle", 3'b000, 1'b0, 1'b0, 3'd0);

        // Reset mid-operation discards credit 2
        step("mr_10", 3'b010, 1'b0, 1'b0, 3'd0);
        step("mr_gap", 3'b000, 1'b0, 1'b0, 3'd0);
        #2 rst = 1'b0;
        #1 lit("mr_clear", 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        step("mr_5", 3'b001, 1'b0, 1'b0, 3'd0);
        step("mr_gap2", 3'b000, 1'b0, 1'b0, 3'd0);
        step("mr_10v", 3'b010, 1'b0, 1'b1, 3'd0);
        step("mr_idle", 3'b000, 1'b0, 1'b0, 3'd0);

        @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
